// File: rtl/cpu_bus1_master.sv
// cpu_bus1_master
//   CPU-side bus-1 master sitting directly upstream of the cache. Takes one
//   single-word request at a time over a valid/ready handshake, serialises it
//   onto the two-cycle A1/D1/C1 protocol (tag/set then offset), releases C1/D1
//   while the cache works, captures the cache response and returns read data
//   and status as a one-cycle completion pulse.
//
// Ports
//   CLK, RESET           clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready is 1 only in IDLE
//   req_cmd              C1 command code (NOP, READ8/16/32, INVALIDATE_LINE, WRITE8/16/32)
//   req_addr             byte address {tag,set,offset}
//   req_wdata            write data, little-endian
//   resp_valid           one-cycle completion pulse
//   resp_err             timeout or NOP request; holds until next completion
//   resp_rdata           read data, zero-extended; holds until next completion
//   a1_out               A1 drive value
//   d1_out/d1_oe/d1_in   D1 drive value, enable and resolved bus value
//   c1_out/c1_oe/c1_in   C1 drive value, enable and resolved bus value
//
// All outputs come straight from flops.

module cpu_bus1_master #(
   parameter int unsigned ADDR1_BUS_SIZE = 15,
   parameter int unsigned DATA1_BUS_SIZE = 16,
   parameter int unsigned CTR1_BUS_SIZE  = 3,
   parameter int unsigned OFFSET_SIZE    = 4,
   parameter int unsigned TIMEOUT        = 256
) (
   input  logic                                    CLK,
   input  logic                                    RESET,
   input  logic                                    req_valid,
   output logic                                    req_ready,
   input  logic [CTR1_BUS_SIZE-1:0]                req_cmd,
   input  logic [ADDR1_BUS_SIZE+OFFSET_SIZE-1:0]   req_addr,
   input  logic [2*DATA1_BUS_SIZE-1:0]             req_wdata,
   output logic                                    resp_valid,
   output logic                                    resp_err,
   output logic [2*DATA1_BUS_SIZE-1:0]             resp_rdata,
   output logic [ADDR1_BUS_SIZE-1:0]               a1_out,
   output logic [DATA1_BUS_SIZE-1:0]               d1_out,
   output logic                                    d1_oe,
   input  logic [DATA1_BUS_SIZE-1:0]               d1_in,
   output logic [CTR1_BUS_SIZE-1:0]                c1_out,
   output logic                                    c1_oe,
   input  logic [CTR1_BUS_SIZE-1:0]                c1_in
);

   localparam int unsigned ADDR_W = ADDR1_BUS_SIZE + OFFSET_SIZE;
   localparam int unsigned WORD_W = 2 * DATA1_BUS_SIZE;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP     = CTR1_BUS_SIZE'(0);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8   = CTR1_BUS_SIZE'(1);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16  = CTR1_BUS_SIZE'(2);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32  = CTR1_BUS_SIZE'(3);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8  = CTR1_BUS_SIZE'(5);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE16 = CTR1_BUS_SIZE'(6);
   localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32 = CTR1_BUS_SIZE'(7);
   localparam logic [CTR1_BUS_SIZE-1:0] C1_RESP     = CTR1_BUS_SIZE'(7);

   typedef enum logic [2:0] {
      StIdle,
      StSend1,
      StSend2,
      StWait,
      StRecv2
   } state_e;

   state_e                      state_q, state_d;
   logic [CTR1_BUS_SIZE-1:0]    cmd_q, cmd_d;
   logic [OFFSET_SIZE-1:0]      offset_q, offset_d;
   logic [DATA1_BUS_SIZE-1:0]   wdata_hi_q, wdata_hi_d;
   logic                        nop_q, nop_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [DATA1_BUS_SIZE-1:0]   rdata_lo_q, rdata_lo_d;

   logic                        req_ready_q, req_ready_d;
   logic                        resp_valid_q, resp_valid_d;
   logic                        resp_err_q, resp_err_d;
   logic [WORD_W-1:0]           resp_rdata_q, resp_rdata_d;
   logic [ADDR1_BUS_SIZE-1:0]   a1_q, a1_d;
   logic [DATA1_BUS_SIZE-1:0]   d1_q, d1_d;
   logic                        d1_oe_q, d1_oe_d;
   logic [CTR1_BUS_SIZE-1:0]    c1_q, c1_d;
   logic                        c1_oe_q, c1_oe_d;

   // Completion request raised by the state decode below.
   logic                        done;
   logic                        done_err;
   logic [WORD_W-1:0]           done_data;

   logic                        req_is_write;

   assign req_is_write = (req_cmd == CMD_WRITE8) || (req_cmd == CMD_WRITE16) ||
                         (req_cmd == CMD_WRITE32);

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      offset_d     = offset_q;
      wdata_hi_d   = wdata_hi_q;
      nop_d        = nop_q;
      cnt_d        = cnt_q;
      rdata_lo_d   = rdata_lo_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      a1_d         = a1_q;
      d1_d         = d1_q;
      d1_oe_d      = d1_oe_q;
      c1_d         = c1_q;
      c1_oe_d      = c1_oe_q;
      done         = 1'b0;
      done_err     = 1'b0;
      done_data    = '0;

      unique case (state_q)
         StIdle: begin
            if (nop_q) begin
               // NOP never touches the bus; it is answered as an error one edge later.
               nop_d    = 1'b0;
               done     = 1'b1;
               done_err = 1'b1;
            end else if (!req_ready_q) begin
               // First edge out of reset.
               req_ready_d = 1'b1;
            end else if (req_valid) begin
               cmd_d       = req_cmd;
               offset_d    = req_addr[OFFSET_SIZE-1:0];
               wdata_hi_d  = req_wdata[WORD_W-1:DATA1_BUS_SIZE];
               req_ready_d = 1'b0;
               if (req_cmd == CMD_NOP) begin
                  nop_d = 1'b1;
               end else begin
                  state_d = StSend1;
                  c1_oe_d = 1'b1;
                  c1_d    = req_cmd;
                  a1_d    = req_addr[ADDR_W-1:OFFSET_SIZE];
                  if (req_is_write) begin
                     d1_oe_d = 1'b1;
                     d1_d    = req_wdata[DATA1_BUS_SIZE-1:0];
                  end else begin
                     d1_oe_d = 1'b0;
                     d1_d    = '0;
                  end
               end
            end
         end

         StSend1: begin
            state_d = StSend2;
            a1_d    = ADDR1_BUS_SIZE'(offset_q);
            if (cmd_q == CMD_WRITE32) begin
               d1_oe_d = 1'b1;
               d1_d    = wdata_hi_q;
            end else begin
               d1_oe_d = 1'b0;
               d1_d    = '0;
            end
         end

         StSend2: begin
            state_d = StWait;
            c1_oe_d = 1'b0;
            c1_d    = '0;
            d1_oe_d = 1'b0;
            d1_d    = '0;
            a1_d    = '0;
            cnt_d   = '0;
         end

         StWait: begin
            if (c1_in == C1_RESP) begin
               case (cmd_q)
                  CMD_READ8: begin
                     done      = 1'b1;
                     done_data = WORD_W'(d1_in[7:0]);
                  end
                  CMD_READ16: begin
                     done      = 1'b1;
                     done_data = WORD_W'(d1_in);
                  end
                  CMD_READ32: begin
                     rdata_lo_d = d1_in;
                     state_d    = StRecv2;
                  end
                  default: begin
                     done = 1'b1;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  done     = 1'b1;
                  done_err = 1'b1;
               end
            end
         end

         StRecv2: begin
            // Upper half follows on the next cycle; C1 is not re-checked.
            done      = 1'b1;
            done_data = {d1_in, rdata_lo_q};
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (done) begin
         state_d      = StIdle;
         resp_valid_d = 1'b1;
         req_ready_d  = 1'b1;
         resp_err_d   = done_err;
         resp_rdata_d = done_data;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= StIdle;
         cmd_q        <= '0;
         offset_q     <= '0;
         wdata_hi_q   <= '0;
         nop_q        <= 1'b0;
         cnt_q        <= '0;
         rdata_lo_q   <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         a1_q         <= '0;
         d1_q         <= '0;
         d1_oe_q      <= 1'b0;
         c1_q         <= '0;
         c1_oe_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         offset_q     <= offset_d;
         wdata_hi_q   <= wdata_hi_d;
         nop_q        <= nop_d;
         cnt_q        <= cnt_d;
         rdata_lo_q   <= rdata_lo_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         a1_q         <= a1_d;
         d1_q         <= d1_d;
         d1_oe_q      <= d1_oe_d;
         c1_q         <= c1_d;
         c1_oe_q      <= c1_oe_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign a1_out     = a1_q;
   assign d1_out     = d1_q;
   assign d1_oe      = d1_oe_q;
   assign c1_out     = c1_q;
   assign c1_oe      = c1_oe_q;

endmodule

// File: doc/cpu_bus1_master.md
Name: cpu_bus1_master

Overview:
- CPU-side bus-1 master directly upstream of the cache.
- Accepts single-word requests from a CPU model over a valid/ready handshake and serialises each one onto the two-cycle A1/D1/C1 cache protocol.
- Releases C1/D1 while the cache works, captures the cache's response, and returns read data and status to the requester.
- Replaces hand-driven A1/D1/C1 stimulus in benches and in the CPU model.

Parameters:
- ADDR1_BUS_SIZE, 15, A1 width; carries {tag,set} in cycle 1 and offset in cycle 2.
- DATA1_BUS_SIZE, 16, D1 width.
- CTR1_BUS_SIZE, 3, C1 width.
- OFFSET_SIZE, 4, byte-offset bits; request address width is ADDR1_BUS_SIZE+OFFSET_SIZE (19).
- TIMEOUT, 256, maximum WAIT cycles before an error response (>=1).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_cmd  in  3  C1 command code: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7.
- req_addr  in  19  byte address.
- req_wdata  in  32  write data, little-endian.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: timeout or illegal command.
- resp_rdata  out  32  read data, zero-extended.
- a1_out  out  ADDR1_BUS_SIZE  A1 drive value.
- d1_out  out  DATA1_BUS_SIZE  D1 drive value.
- d1_oe  out  1  D1 output enable.
- d1_in  in  DATA1_BUS_SIZE  resolved D1 bus value.
- c1_out  out  CTR1_BUS_SIZE  C1 drive value.
- c1_oe  out  1  C1 output enable.
- c1_in  in  CTR1_BUS_SIZE  resolved C1 bus value; response code is 7.

Behaviour:
- All outputs are registered.
- Reset, applied asynchronously: every output is 0 (req_ready=0, c1_oe=0, d1_oe=0, resp_*=0), state is IDLE, timeout counter is 0.
- req_ready rises on the first posedge after RESET deasserts. It is 1 only in IDLE.
- States: IDLE, SEND1, SEND2, WAIT, RECV2.

IDLE:
- An edge with req_valid&&req_ready accepts the request: cmd, addr and wdata are latched, req_ready goes 0, resp_valid clears.
- cmd=NOP: no bus activity. The next edge gives resp_valid=1, resp_err=1, resp_rdata=0, and req_ready=1.
- Otherwise the same edge enters SEND1 and drives:
  - c1_oe=1, c1_out=cmd
  - a1_out=addr[18:4]
  - d1_oe=1 for WRITE*, 0 otherwise
  - d1_out=wdata[15:0] for WRITE*, 0 otherwise

SEND1 -> SEND2 (one edge):
- a1_out = offset addr[3:0], zero-extended; c1 is held.
- WRITE32: d1_out=wdata[31:16], d1_oe stays 1.
- All other commands: d1_oe=0.

SEND2 -> WAIT (one edge):
- c1_oe=0, c1_out=0, d1_oe=0, a1_out=0.
- Timeout counter cleared.

WAIT, evaluated each edge:
- If c1_in==7:
  - READ8: rdata={24'b0,d1_in[7:0]}, complete.
  - READ16: rdata={16'b0,d1_in}, complete.
  - READ32: rdata[15:0]=d1_in, go to RECV2.
  - Write or invalidate: complete with rdata=0.
- Else the counter increments. When it reaches TIMEOUT, complete with resp_err=1 and rdata=0.
- c1_in is sampled starting from the first edge after entering WAIT.

RECV2:
- The next edge captures rdata[31:16]=d1_in and completes. c1_in is not checked.

Complete:
- Same edge: resp_valid=1, req_ready=1, state IDLE.
- The next edge clears resp_valid, even if a new request is accepted on that edge.
- resp_rdata and resp_err hold until the next completion.
- resp_valid and req_ready may be 1 together, so back-to-back requests lose no cycle.

Other rules:
- req_valid is ignored when req_ready=0. Request inputs are ignored after the accept edge.
- The block never drives C1 or D1 in WAIT or RECV2; bus contention is the cache's side only.
- RESET mid-transaction aborts it: enables drop immediately, no resp_valid is produced, and the next request starts a fresh SEND1.

Test Plan:
1. Reset, then READ8 addr 0x12345. Required drive: SEND1 C1=1, A1=0x1234, d1_oe=0; SEND2 A1=0x0005. Cache answers C1=7, D1=0x00AB after 3 WAIT cycles -> resp_valid for 1 cycle, resp_rdata=0x000000AB, resp_err=0.
2. WRITE32 addr 0x00010, data 0xDEADBEEF. Required drive: SEND1 C1=7, A1=0x0001, D1=0xBEEF; SEND2 A1=0x0000, D1=0xDEAD; then c1_oe=d1_oe=0. Cache responds C1=7 -> resp_valid, resp_err=0, resp_rdata=0.
3. READ32 addr 0x7FFFF, cache responds D1=0x5678 then 0x1234 -> resp_rdata=0x12345678. A second request held valid is accepted on the resp_valid edge.
4. TIMEOUT=8, INVALIDATE_LINE with no response -> resp_valid with resp_err=1 on the 8th WAIT edge; req_ready=1 on that same edge.
5. RESET asserted mid-WAIT of a READ16 -> all outputs 0 immediately, no resp_valid. A following READ16 completes normally.
6. Request with cmd=NOP -> resp_err=1 on the next edge; c1_oe and d1_oe stay 0 throughout.
